// File: rtl/byte_word_packer.sv
// byte_word_packer: packs the arbiter's byte stream into 32-bit words. Bytes fill lanes
// little-endian in arrival order. Complete or flushed words go into a show-ahead word FIFO,
// which drains through a valid/ready handshake.
module byte_word_packer #(
    parameter int unsigned WDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        flush,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes,
    output logic        out_valid,
    output logic        overflow,
    output logic [15:0] word_count
);

    localparam int unsigned AW = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [1:0]    idx;
    logic [31:0]   lanes;
    logic [31:0]   mem_data  [WDEPTH];
    logic [2:0]    mem_bytes [WDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    logic [31:0]   asm_next;
    logic [2:0]    held;
    logic          push;
    logic          pop;
    logic          full;
    logic          accept;

    // Assembler view including this edge's byte, plus push/pop/accept decisions
    always_comb begin
        asm_next = lanes;
        if (in_valid) begin
            asm_next[{idx, 3'b000} +: 8] = in_data;
        end
        held   = {1'b0, idx} + {2'b00, in_valid};
        push   = (held == 3'd4) || (flush && (held != 3'd0));
        pop    = (cnt != '0) && out_ready;
        full   = (cnt == CW'(WDEPTH));
        // A pop on the same edge frees the slot a push into a full FIFO needs
        accept = push && (!full || pop);
    end

    // Show-ahead head: zeros when empty so downstream never sees stale words
    assign out_valid = (cnt != '0);
    assign out_data  = out_valid ? mem_data[rd_ptr]  : 32'd0;
    assign out_bytes = out_valid ? mem_bytes[rd_ptr] : 3'd0;

    // Assembler lane index and partial-word data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= 2'd0;
            lanes <= 32'd0;
        end else if (push) begin
            // Lanes restart on every push, even when the word is dropped
            idx   <= 2'd0;
            lanes <= 32'd0;
        end else if (in_valid) begin
            idx   <= idx + 2'd1;
            lanes <= asm_next;
        end
    end

    // Word storage; contents only matter while counted as occupied
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            mem_data[wr_ptr]  <= asm_next;
            mem_bytes[wr_ptr] <= held;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and accepted-word counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            overflow   <= 1'b0;
            word_count <= 16'd0;
        end else begin
            if (accept) begin
                wr_ptr     <= wr_ptr + AW'(1);
                word_count <= word_count + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (accept && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !accept) begin
                cnt <= cnt - CW'(1);
            end
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
